// File: rtl/sal_dram_cmd_issue_pkg.sv
// sal_dram_cmd_issue_pkg: shared DDR command encodings and field types
// for the command-issue stage and its data-window helper.
package sal_dram_cmd_issue_pkg;

   localparam int DEF_BK_CNT    = 8;
   localparam int DEF_RA_WIDTH  = 16;
   localparam int DEF_CA_WIDTH  = 10;
   localparam int DEF_ID_WIDTH  = 4;
   localparam int DEF_LEN_WIDTH = 8;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_RD    = 4'b0101;
   localparam logic [3:0] CMD_WR    = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;

   typedef logic [$clog2(DEF_BK_CNT)-1:0] dram_ba_t;
   typedef logic [DEF_RA_WIDTH-1:0]       dram_ra_t;
   typedef logic [DEF_CA_WIDTH-1:0]       dram_ca_t;
   typedef logic [DEF_ID_WIDTH-1:0]       axi_id_t;
   typedef logic [DEF_LEN_WIDTH-1:0]      axi_len_t;

endpackage

// File: rtl/sal_dram_cmd_issue_window.sv
// sal_data_window: LAT-stage delay line feeding a BURST_CYC-beat window
// with a latched tag. Ports: push/tag_in in; pre_en, en, first, last,
// tag_out, ovl (window restarted while beats remained) out.
module sal_data_window #(
   parameter int LAT       = 6,
   parameter int BURST_CYC = 4,
   parameter int TAG_W     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [TAG_W-1:0] tag_in,
   output logic             pre_en,
   output logic             en,
   output logic             first,
   output logic             last,
   output logic [TAG_W-1:0] tag_out,
   output logic             ovl
);

   localparam int            CW      = $clog2(BURST_CYC + 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(BURST_CYC - 1);

   logic [LAT-1:0]   dl_vld;
   logic [TAG_W-1:0] dl_tag [LAT];
   logic [CW-1:0]    cnt;
   logic             emerge;

   assign emerge = dl_vld[LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         dl_vld  <= '0;
         for (int i = 0; i < LAT; i++) dl_tag[i] <= '0;
         en      <= 1'b0;
         cnt     <= '0;
         tag_out <= '0;
      end else begin
         dl_vld[0] <= push;
         dl_tag[0] <= tag_in;
         for (int i = 1; i < LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_tag[i] <= dl_tag[i-1];
         end
         // a new emergence always wins and restarts the window
         if (emerge) begin
            en      <= 1'b1;
            cnt     <= CNT_TOP;
            tag_out <= dl_tag[LAT-1];
         end else if (en) begin
            if (cnt == '0) en <= 1'b0;
            else           cnt <= cnt - CW'(1);
         end
      end
   end

   assign first  = en && (cnt == CNT_TOP);
   assign last   = en && (cnt == '0);
   // one cycle ahead of en: emergence plus every non-final beat
   assign pre_en = emerge || (en && (cnt != '0));
   assign ovl    = emerge && en && (cnt != '0);

endmodule

// File: rtl/sal_dram_cmd_issue.sv
// sal_dram_cmd_issue: registers the granted command onto DDR pins and
// times read-capture / write-launch windows. Ports: *_gnt + fields in;
// cmd_* pins, rd_*/wr_* window strobes, sticky proto_err out.
module sal_dram_cmd_issue
   import sal_dram_cmd_issue_pkg::*;
#(
   parameter int BK_CNT    = 8,
   parameter int RA_WIDTH  = 16,
   parameter int CA_WIDTH  = 10,
   parameter int ID_WIDTH  = 4,
   parameter int LEN_WIDTH = 8,
   parameter int CL        = 6,
   parameter int CWL       = 5,
   parameter int BURST_CYC = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      act_gnt,
   input  logic                      rd_gnt,
   input  logic                      wr_gnt,
   input  logic                      pre_gnt,
   input  logic                      ref_gnt,
   input  logic [$clog2(BK_CNT)-1:0] ba,
   input  logic [RA_WIDTH-1:0]       ra,
   input  logic [CA_WIDTH-1:0]       ca,
   input  logic [ID_WIDTH-1:0]       id,
   input  logic [LEN_WIDTH-1:0]      len,
   output logic                      cmd_cs_n,
   output logic                      cmd_ras_n,
   output logic                      cmd_cas_n,
   output logic                      cmd_we_n,
   output logic [$clog2(BK_CNT)-1:0] cmd_ba,
   output logic [RA_WIDTH-1:0]       cmd_addr,
   output logic                      rd_en,
   output logic                      rd_first,
   output logic                      rd_last,
   output logic [ID_WIDTH-1:0]       rd_id,
   output logic [LEN_WIDTH-1:0]      rd_len,
   output logic                      wr_pop,
   output logic                      wr_en,
   output logic                      wr_last,
   output logic                      proto_err
);

   localparam int BA_W  = $clog2(BK_CNT);
   localparam int TAG_W = ID_WIDTH + LEN_WIDTH;

   logic [3:0]          cmd_d;
   logic [BA_W-1:0]     ba_d;
   logic [RA_WIDTH-1:0] addr_d;
   logic [RA_WIDTH-1:0] col_addr;
   logic                rd_push;
   logic                wr_push;
   logic                multi;
   logic                rd_ovl;
   logic                wr_ovl;
   logic [TAG_W-1:0]    rd_tag;
   logic                rd_pre_unused;
   logic                wr_first_unused;
   logic [0:0]          wr_tag_unused;

   assign multi = (act_gnt & (rd_gnt | wr_gnt | pre_gnt | ref_gnt))
                | (rd_gnt & (wr_gnt | pre_gnt | ref_gnt))
                | (wr_gnt & (pre_gnt | ref_gnt))
                | (pre_gnt & ref_gnt);

   always_comb begin
      col_addr     = RA_WIDTH'(ca);
      col_addr[10] = 1'b0;
      cmd_d        = CMD_DESEL;
      ba_d         = '0;
      addr_d       = '0;
      rd_push      = 1'b0;
      wr_push      = 1'b0;
      if (act_gnt) begin
         cmd_d  = CMD_ACT;
         ba_d   = ba;
         addr_d = ra;
      end else if (rd_gnt) begin
         cmd_d   = CMD_RD;
         ba_d    = ba;
         addr_d  = col_addr;
         rd_push = 1'b1;
      end else if (wr_gnt) begin
         cmd_d   = CMD_WR;
         ba_d    = ba;
         addr_d  = col_addr;
         wr_push = 1'b1;
      end else if (pre_gnt) begin
         cmd_d = CMD_PRE;
         ba_d  = ba;
      end else if (ref_gnt) begin
         cmd_d = CMD_REF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_DESEL;
         cmd_ba    <= '0;
         cmd_addr  <= '0;
         proto_err <= 1'b0;
      end else begin
         {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= cmd_d;
         cmd_ba    <= ba_d;
         cmd_addr  <= addr_d;
         proto_err <= proto_err | multi | rd_ovl | wr_ovl
                    | (rd_en & wr_en);
      end
   end

   sal_data_window #(
      .LAT       (CL),
      .BURST_CYC (BURST_CYC),
      .TAG_W     (TAG_W)
   ) u_rd_win (
      .clk     (clk),
      .rst     (rst),
      .push    (rd_push),
      .tag_in  ({id, len}),
      .pre_en  (rd_pre_unused),
      .en      (rd_en),
      .first   (rd_first),
      .last    (rd_last),
      .tag_out (rd_tag),
      .ovl     (rd_ovl)
   );

   assign rd_id  = rd_tag[TAG_W-1:LEN_WIDTH];
   assign rd_len = rd_tag[LEN_WIDTH-1:0];

   sal_data_window #(
      .LAT       (CWL),
      .BURST_CYC (BURST_CYC),
      .TAG_W     (1)
   ) u_wr_win (
      .clk     (clk),
      .rst     (rst),
      .push    (wr_push),
      .tag_in  (1'b0),
      .pre_en  (wr_pop),
      .en      (wr_en),
      .first   (wr_first_unused),
      .last    (wr_last),
      .tag_out (wr_tag_unused),
      .ovl     (wr_ovl)
   );

endmodule
